player_shot_ctrl: RTL

//   Player bullet pool; sits downstream of the player-movement block.
//   - Consumes player_x/player_y and a fire button; spawns, moves and retires up to NUM_SHOTS upward bullets.
//   - Exports slot positions to the collision stage; accepts per-slot kills back from it.
//   - Renders bullets for the current VGA pixel (shot_on/rgb_out into the pixel mux).

---
 rtl/stg_pkg.sv | 17 +
 rtl/stg_tick_div.sv | 27 ++
 rtl/player_shot_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/stg_pkg.sv
// Shared constants and helpers for the shooter blocks (player, enemies, shots).
// Screen geometry, colour formats and a width helper sized for slot indices and counters.
package stg_pkg;

  localparam int MAX_X = 384;
  localparam int MAX_Y = 448;
  localparam int COORD_W = 10;
  localparam int RGB_W = 12;
  localparam logic [RGB_W-1:0] COLOR_KEY = 12'hCCC;
  localparam int PLAYER_HALF_H = 23;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stg_tick_div.sv
// Movement tick divider: free-running counter 0..TICK_MAX-1.
// tick is high for the single cycle in which the counter sits at TICK_MAX-1.
module stg_tick_div
  import stg_pkg::*;
#(
  parameter int TICK_MAX = 500000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = idx_width(TICK_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(TICK_MAX - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/player_shot_ctrl.sv
// Player bullet pool: spawns shots above the player on fire, moves them up each tick,
// retires them at the top or on a kill from the collision stage, and renders them per pixel.
module player_shot_ctrl
  import stg_pkg::*;
#(
  parameter int              NUM_SHOTS      = 4,
  parameter int              TICK_MAX       = 500000,
  parameter int              SHOT_SPEED     = 4,
  parameter int              COOLDOWN_TICKS = 8,
  parameter int              SHOT_HALF_W    = 2,
  parameter int              SHOT_H         = 8,
  parameter int              SPAWN_DY       = 24,
  parameter logic [RGB_W-1:0] SHOT_RGB      = 12'hFF0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [COORD_W-1:0]           x,
  input  logic [COORD_W-1:0]           y,
  input  logic                         video_on,
  input  logic                         game_state,
  input  logic                         ctrl_fire,
  input  logic [COORD_W-1:0]           player_x,
  input  logic [COORD_W-1:0]           player_y,
  input  logic                         hit_valid,
  input  logic [2:0]                   hit_idx,
  output logic [NUM_SHOTS-1:0]         shot_active,
  output logic [COORD_W*NUM_SHOTS-1:0] shot_x_flat,
  output logic [COORD_W*NUM_SHOTS-1:0] shot_y_flat,
  output logic                         fired,
  output logic                         shot_on,
  output logic [RGB_W-1:0]             rgb_out
);

  localparam int SLOT_W = idx_width(NUM_SHOTS);
  localparam int CD_W   = idx_width(COOLDOWN_TICKS + 1);

  localparam logic [COORD_W-1:0] SPEED_C = COORD_W'(SHOT_SPEED);
  localparam logic [COORD_W-1:0] DY_C    = COORD_W'(SPAWN_DY);
  localparam logic [CD_W-1:0]    CD_C    = CD_W'(COOLDOWN_TICKS);
  localparam logic [COORD_W:0]   HW_C    = (COORD_W+1)'(SHOT_HALF_W);
  localparam logic [COORD_W:0]   H_C     = (COORD_W+1)'(SHOT_H);

  logic tick;

  stg_tick_div #(.TICK_MAX(TICK_MAX)) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  logic [NUM_SHOTS-1:0] active_q, active_d;
  logic [COORD_W-1:0]   sx_q [NUM_SHOTS];
  logic [COORD_W-1:0]   sx_d [NUM_SHOTS];
  logic [COORD_W-1:0]   sy_q [NUM_SHOTS];
  logic [COORD_W-1:0]   sy_d [NUM_SHOTS];
  logic [CD_W-1:0]      cd_q, cd_d;
  logic                 fired_q, fired_d;
  logic                 shot_on_q, shot_on_d;
  logic [RGB_W-1:0]     rgb_q, rgb_d;

  logic [NUM_SHOTS-1:0] kill_mask;
  logic [NUM_SHOTS-1:0] free_mask;
  logic                 spawn_found;
  logic [SLOT_W-1:0]    spawn_idx;
  logic                 fire_ok;
  logic [COORD_W-1:0]   spawn_y;

  // Free slots exclude a slot being killed this cycle, so a kill is never
  // immediately backfilled by a spawn on the same edge.
  always_comb begin
    kill_mask = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (hit_valid && (hit_idx == 3'(i))) kill_mask[i] = 1'b1;
    end
    free_mask   = ~active_q & ~kill_mask;
    spawn_found = 1'b0;
    spawn_idx   = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        spawn_found = 1'b1;
        spawn_idx   = SLOT_W'(i);
      end
    end
    fire_ok = tick && ctrl_fire && game_state && (cd_q == '0) && spawn_found;
    spawn_y = (player_y >= DY_C) ? (player_y - DY_C) : '0;
  end

  always_comb begin
    active_d = active_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    cd_d     = cd_q;
    fired_d  = 1'b0;
    if (!game_state) begin
      active_d = '0;
      cd_d     = '0;
    end else begin
      if (tick) begin
        if (fire_ok)           cd_d = CD_C;
        else if (cd_q != '0)   cd_d = cd_q - 1'b1;
      end
      fired_d = fire_ok;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        if (kill_mask[i]) begin
          active_d[i] = 1'b0;
        end else if (tick) begin
          if (fire_ok && (spawn_idx == SLOT_W'(i))) begin
            active_d[i] = 1'b1;
            sx_d[i]     = player_x;
            sy_d[i]     = spawn_y;
          end else if (active_q[i]) begin
            // Retire rather than wrap once the shot can no longer take a full step.
            if (sy_q[i] >= SPEED_C) sy_d[i] = sy_q[i] - SPEED_C;
            else                    active_d[i] = 1'b0;
          end
        end
      end
    end
  end

  // Bounds are compared one bit wider so sx < SHOT_HALF_W cannot underflow.
  always_comb begin
    logic [NUM_SHOTS-1:0] hit;
    hit = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      hit[i] = active_q[i]
            && (({1'b0, x} + HW_C) >= {1'b0, sx_q[i]})
            && ({1'b0, x} < ({1'b0, sx_q[i]} + HW_C))
            && ({1'b0, y} >= {1'b0, sy_q[i]})
            && ({1'b0, y} < ({1'b0, sy_q[i]} + H_C));
    end
    shot_on_d = video_on && (|hit);
    rgb_d     = shot_on_d ? SHOT_RGB : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= '0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        sx_q[i] <= '0;
        sy_q[i] <= '0;
      end
      cd_q      <= '0;
      fired_q   <= 1'b0;
      shot_on_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      active_q  <= active_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      cd_q      <= cd_d;
      fired_q   <= fired_d;
      shot_on_q <= shot_on_d;
      rgb_q     <= rgb_d;
    end
  end

  assign shot_active = active_q;
  assign fired       = fired_q;
  assign shot_on     = shot_on_q;
  assign rgb_out     = rgb_q;

  for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_flat
    assign shot_x_flat[COORD_W*g +: COORD_W] = sx_q[g];
    assign shot_y_flat[COORD_W*g +: COORD_W] = sy_q[g];
  end

endmodule
